// File: rtl/pc_branch_seq.sv
// Program-counter sequencer and branch resolver for the 16-bit single-cycle core.
// Drives both next-PC candidates and the branch-select line, and owns the PC, flush and halt state.
module pc_branch_seq #(
  parameter int unsigned PC_W         = 6,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_offset,
  input  logic            flag_z,
  input  logic            flag_n,
  input  logic            flag_c,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next_seq,
  output logic [PC_W-1:0] pc_br_target,
  output logic            br_sel,
  output logic            flush,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_INIT  = PC_W'(RESET_PC);
  localparam logic [1:0]      CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            halted_q, halted_d;
  logic            cond_true;
  logic            taken;

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = ~flag_z;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = ~flag_n;
      3'b101:  cond_true = flag_c;
      3'b110:  cond_true = ~flag_c;
      default: cond_true = 1'b0;
    endcase
  end

  // Same-width add is equivalent to adding the sign-extended offset modulo 2**PC_W.
  assign pc_next_seq  = pc_q + PC_W'(1);
  assign pc_br_target = pc_q + br_offset;
  assign taken        = br_valid & cond_true;
  assign br_sel       = taken & (state_q == S_RUN) & ~stall & ~halt_req;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    halted_d = halted_q;
    case (state_q)
      S_RUN: begin
        if (halt_req) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (br_sel) begin
          pc_d    = pc_br_target;
          state_d = S_FLUSH;
          flush_d = 1'b1;
          cnt_d   = CNT_LOAD;
        end else begin
          pc_d = pc_next_seq;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 2'd0) begin
          state_d = S_RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= PC_INIT;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign flush  = flush_q;
  assign halted = halted_q;

endmodule
